// File: rtl/pulse_sched_pkg.sv
// Shared types and default channel timing for the pulse scheduler slice.
package pulse_sched_pkg;

  localparam int NREQ          = 4;
  localparam int CNT_W_DEF     = 9;
  localparam int LEN0_DEF      = 131;
  localparam int LEN1_DEF      = 120;
  localparam int LEN2_DEF      = 87;
  localparam int LEN3_DEF      = 54;
  localparam int GAP_TICKS_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    PULSE,
    GAP
  } state_t;

endpackage

// File: rtl/pulse_sched_if.sv
// Request/auto inputs and pulse/status outputs of the pulse scheduler.
interface pulse_sched_if;
  import pulse_sched_pkg::*;

  logic            tick;
  logic [NREQ-1:0] req;
  logic            auto_en;
  logic            out;
  logic            busy;
  logic [NREQ-1:0] grant;
  logic            done;

  modport master (output tick, req, auto_en, input out, busy, grant, done);
  modport slave  (input tick, req, auto_en, output out, busy, grant, done);

endinterface

// File: rtl/pulse_sched_rr_arbiter.sv
// Combinational pick of the first pending channel at or after ptr (wrapping).
// With PULSE_SCHED_FIXED_PRIO_EN the search always starts at channel 0.
module pulse_sched_rr_arbiter
  import pulse_sched_pkg::*;
(
  input  logic [NREQ-1:0] pending,
  input  logic [1:0]      ptr,
  output logic [NREQ-1:0] gnt,
  output logic [1:0]      idx
);

  logic [1:0] start;
  logic [1:0] c;

`ifdef PULSE_SCHED_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;
  assign start      = 2'd0;
`else
  assign start = ptr;
`endif

  // Scan from farthest to nearest so the nearest pending channel is written last.
  always_comb begin
    gnt = '0;
    idx = '0;
    c   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      c = start + 2'(k);
      if (pending[c]) begin
        gnt = NREQ'(1) << c;
        idx = c;
      end
    end
  end

endmodule

// File: rtl/pulse_sched.sv
// Shares one serial pulse output among four requesters; grant 1 sysclk after pending,
// pulse edges tick-aligned; no backpressure, requests queue. Option: PULSE_SCHED_FIXED_PRIO_EN.
module pulse_sched
  import pulse_sched_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int LEN0      = LEN0_DEF,
  parameter int LEN1      = LEN1_DEF,
  parameter int LEN2      = LEN2_DEF,
  parameter int LEN3      = LEN3_DEF,
  parameter int GAP_TICKS = GAP_TICKS_DEF
) (
  input  logic         sysclk,
  input  logic         rst,
  pulse_sched_if.slave bus
);

  // Zero-length channels can never become pending.
  localparam logic [NREQ-1:0] LEN_NZ = {(LEN3 != 0), (LEN2 != 0), (LEN1 != 0), (LEN0 != 0)};

  state_t            state_q, state_d;
  logic [NREQ-1:0]   req_q;
  logic [NREQ-1:0]   rise;
  logic [NREQ-1:0]   pending_q, pending_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  gap_q, gap_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [1:0]        idx_q, idx_d;
  logic              out_q, out_d;
  logic              done_q, done_d;
  logic [1:0]        ptr_q;
  logic [NREQ-1:0]   arb_gnt;
  logic [1:0]        arb_idx;
  logic [CNT_W-1:0]  len_sel;
  logic              gap_done;

  assign rise     = bus.req & ~req_q;
  assign gap_done = (state_q == GAP) && bus.tick &&
                    ((gap_q + CNT_W'(1)) == CNT_W'(GAP_TICKS));

  pulse_sched_rr_arbiter u_arb (
    .pending (pending_q),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .idx     (arb_idx)
  );

  always_comb begin
    case (idx_q)
      2'd0:    len_sel = CNT_W'(LEN0);
      2'd1:    len_sel = CNT_W'(LEN1);
      2'd2:    len_sel = CNT_W'(LEN2);
      default: len_sel = CNT_W'(LEN3);
    endcase
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    gap_d     = gap_q;
    grant_d   = grant_q;
    idx_d     = idx_q;
    out_d     = out_q;
    done_d    = 1'b0;
    pending_d = pending_q;
    case (state_q)
      IDLE: begin
        if (|pending_q) begin
          grant_d   = arb_gnt;
          idx_d     = arb_idx;
          pending_d = pending_q & ~arb_gnt;
          state_d   = ARM;
        end
      end
      ARM: begin
        if (bus.tick) begin
          out_d   = 1'b1;
          count_d = CNT_W'(1);
          state_d = PULSE;
        end
      end
      PULSE: begin
        if (bus.tick) begin
          if (count_q == len_sel) begin
            out_d   = 1'b0;
            done_d  = 1'b1;
            gap_d   = '0;
            state_d = GAP;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      GAP: begin
        if (bus.tick) begin
          gap_d = gap_q + CNT_W'(1);
          if (gap_done) begin
            grant_d = '0;
            state_d = IDLE;
            if (bus.auto_en) begin
              pending_d = pending_d | bus.req;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // A fresh edge lands after the grant clear, so a same-cycle re-request survives.
    pending_d = (pending_d | rise) & LEN_NZ;
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      req_q     <= '0;
      pending_q <= '0;
      count_q   <= '0;
      gap_q     <= '0;
      grant_q   <= '0;
      idx_q     <= '0;
      out_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= bus.req;
      pending_q <= pending_d;
      count_q   <= count_d;
      gap_q     <= gap_d;
      grant_q   <= grant_d;
      idx_q     <= idx_d;
      out_q     <= out_d;
      done_q    <= done_d;
    end
  end

`ifdef PULSE_SCHED_FIXED_PRIO_EN
  assign ptr_q = 2'd0;
`else
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (gap_done) begin
      ptr_q <= idx_q + 2'd1;
    end
  end
`endif

  assign bus.out   = out_q;
  assign bus.busy  = (state_q != IDLE);
  assign bus.grant = grant_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_pulse_sched.sv
// Directed plus random checks of pulse_sched against a service-order model.
module tb_pulse_sched;
  import pulse_sched_pkg::*;

  logic sysclk;
  logic rst;

  pulse_sched_if b ();
  pulse_sched_if bz ();

  pulse_sched #(.CNT_W(9), .LEN0(3), .LEN1(5), .LEN2(2), .LEN3(4), .GAP_TICKS(2)) dut (
    .sysclk (sysclk),
    .rst    (rst),
    .bus    (b)
  );

  pulse_sched #(.CNT_W(9), .LEN0(3), .LEN1(5), .LEN2(2), .LEN3(0), .GAP_TICKS(2)) dut_z (
    .sysclk (sysclk),
    .rst    (rst),
    .bus    (bz)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int obs_idx[$];
  int obs_len[$];
  int done_cnt = 0;
  int min_lo   = 1000000;
  int m_ptr    = 0;

  function automatic int len_of(input int c);
    case (c)
      0:       return 3;
      1:       return 5;
      2:       return 2;
      default: return 4;
    endcase
  endfunction

  function automatic int oh2i(input logic [3:0] g);
    case (g)
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return 99;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Service order: each decision takes the first pending channel at or after the
  // channel following the last one served; re-arm adds held requests after the
  // first `rearms` pulses.
  task automatic model(input logic [3:0] pend0, input logic [3:0] held, input int rearms,
                       output int exp_q[$]);
    logic [3:0] pend;
    int c;
    int ch;
    int start;
    pend = pend0;
    exp_q = {};
    while (pend != 4'b0) begin
`ifdef PULSE_SCHED_FIXED_PRIO_EN
      start = 0;
`else
      start = m_ptr;
`endif
      c = -1;
      for (int k = 0; k < 4; k++) begin
        ch = (start + k) % 4;
        if (c < 0 && pend[2'(ch)]) c = ch;
      end
      exp_q.push_back(c);
      pend = pend & ~(4'b0001 << c);
      m_ptr = (c + 1) % 4;
      if (exp_q.size() <= rearms) pend = pend | held;
    end
  endtask

  task automatic check_run(input string tag, input int e[$], input int base, input int d0);
    chk({tag, "_npulse"}, obs_len.size() - base, e.size());
    chk({tag, "_ndone"}, done_cnt - d0, e.size());
    foreach (e[i]) begin
      chk({tag, "_ch"}, (base + i < obs_idx.size()) ? obs_idx[base + i] : -1, e[i]);
      chk({tag, "_len"}, (base + i < obs_len.size()) ? obs_len[base + i] : -1, 4 * len_of(e[i]));
    end
  endtask

  task automatic wait_idle();
    int q = 0;
    int n = 0;
    repeat (3) @(negedge sysclk);
    while (q < 4 && n < 1500) begin
      @(negedge sysclk);
      n++;
      if (b.busy === 1'b1) q = 0;
      else q++;
    end
    chk("idle_timeout", q, 4);
  endtask

  initial begin
    sysclk = 1'b0;
    forever #5 sysclk = ~sysclk;
  end

  // Baud tick: one sysclk high out of every four.
  initial begin
    b.tick  = 1'b0;
    bz.tick = 1'b0;
    forever begin
      repeat (3) @(negedge sysclk);
      b.tick  = 1'b1;
      bz.tick = 1'b1;
      @(negedge sysclk);
      b.tick  = 1'b0;
      bz.tick = 1'b0;
    end
  end

  // Pulse recorder: channel at each rising edge, high/low widths in sysclk cycles.
  initial begin
    logic out_p;
    int hi;
    int lo;
    bit seen_fall;
    out_p = 1'b0;
    hi = 0;
    lo = 0;
    seen_fall = 1'b0;
    forever begin
      @(negedge sysclk);
      if (rst) seen_fall = 1'b0;
      if (b.out === 1'b1 && !out_p) begin
        obs_idx.push_back(oh2i(b.grant));
        hi = 1;
        if (seen_fall && lo < min_lo) min_lo = lo;
      end else if (b.out === 1'b1) begin
        hi++;
      end else if (out_p) begin
        obs_len.push_back(hi);
        seen_fall = !rst;
        lo = 1;
      end else begin
        lo++;
      end
      if (b.done === 1'b1) done_cnt++;
      out_p = (b.out === 1'b1);
    end
  end

  initial begin
    int e[$];
    int e2[$];
    int base;
    int d0;
    int t;
    int sb;
    int sg;
    int sd;
    logic [3:0] m;

    rst        = 1'b0;
    b.req      = '0;
    b.auto_en  = 1'b0;
    bz.req     = '0;
    bz.auto_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_out", 32'(b.out), 0);
    chk("rst_busy", 32'(b.busy), 0);
    chk("rst_grant", 32'(b.grant), 0);
    chk("rst_done", 32'(b.done), 0);
    repeat (3) @(negedge sysclk);
    rst = 1'b0;
    repeat (2) @(negedge sysclk);

    // Single request on channel 0
    base = obs_len.size();
    d0   = done_cnt;
    b.req = 4'b0001;
    t = 0;
    while (b.busy !== 1'b1 && t < 20) begin
      @(negedge sysclk);
      t++;
    end
    chk("t1_grant", 32'(b.grant), 1);
    chk("t1_out_armed_low", 32'(b.out), 0);
    wait_idle();
    chk("t1_busy_end", 32'(b.busy), 0);
    chk("t1_grant_end", 32'(b.grant), 0);
    b.req = '0;
    repeat (2) @(negedge sysclk);
    model(4'b0001, 4'b0000, 0, e);
    check_run("t1", e, base, d0);

    // All four edges in one cycle
    base = obs_len.size();
    d0   = done_cnt;
    b.req = 4'b1111;
    wait_idle();
    b.req = '0;
    repeat (2) @(negedge sysclk);
    model(4'b1111, 4'b0000, 0, e);
    check_run("t2_all", e, base, d0);

    // Auto mode with two held channels; drop auto during the fourth pulse
    base = obs_len.size();
    d0   = done_cnt;
    b.auto_en = 1'b1;
    b.req     = 4'b0011;
    t = 0;
    while (obs_idx.size() < base + 4 && t < 1500) begin
      @(negedge sysclk);
      t++;
    end
    b.auto_en = 1'b0;
    wait_idle();
    b.req = '0;
    repeat (2) @(negedge sysclk);
    model(4'b0011, 4'b0011, 3, e);
    check_run("t3_auto", e, base, d0);

    // Re-request channel 2 during its own pulse
    base = obs_len.size();
    d0   = done_cnt;
    b.req = 4'b0100;
    t = 0;
    while (!(b.out === 1'b1 && b.grant === 4'b0100) && t < 200) begin
      @(negedge sysclk);
      t++;
    end
    b.req = '0;
    @(negedge sysclk);
    b.req = 4'b0100;
    wait_idle();
    b.req = '0;
    repeat (2) @(negedge sysclk);
    model(4'b0100, 4'b0000, 0, e);
    model(4'b0100, 4'b0000, 0, e2);
    e = {e, e2};
    check_run("t4_rereq", e, base, d0);

    // Asynchronous reset in the middle of a channel-1 pulse
    d0 = done_cnt;
    b.req = 4'b0010;
    t = 0;
    while (!(b.out === 1'b1 && b.grant === 4'b0010) && t < 200) begin
      @(negedge sysclk);
      t++;
    end
    repeat (4) @(negedge sysclk);
    #2 rst = 1'b1;
    #1;
    chk("t5_out_async", 32'(b.out), 0);
    chk("t5_grant_async", 32'(b.grant), 0);
    chk("t5_busy_async", 32'(b.busy), 0);
    repeat (2) @(negedge sysclk);
    chk("t5_no_done", done_cnt - d0, 0);
    rst   = 1'b0;
    m_ptr = 0;
    base  = obs_len.size();
    d0    = done_cnt;
    wait_idle();
    b.req = '0;
    repeat (2) @(negedge sysclk);
    model(4'b0010, 4'b0000, 0, e);
    check_run("t5_after_rst", e, base, d0);

    // Zero-length channel never gets served
    sb = 0;
    sg = 0;
    sd = 0;
    bz.req = 4'b1000;
    repeat (40) begin
      @(negedge sysclk);
      if (bz.busy !== 1'b0) sb++;
      if (bz.grant !== 4'b0000) sg++;
      if (bz.done !== 1'b0) sd++;
    end
    bz.req = '0;
    chk("t6_len0_busy", sb, 0);
    chk("t6_len0_grant", sg, 0);
    chk("t6_len0_done", sd, 0);

    // Random request masks at random offsets from the tick
    for (int it = 0; it < 8; it++) begin
      m = 4'($urandom_range(1, 15));
      repeat ($urandom_range(0, 3)) @(negedge sysclk);
      base = obs_len.size();
      d0   = done_cnt;
      b.req = m;
      wait_idle();
      b.req = '0;
      repeat (2) @(negedge sysclk);
      model(m, 4'b0000, 0, e);
      check_run("t7_rand", e, base, d0);
    end

    chk("min_low_gap", 32'(min_lo >= 8), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
